// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_bank slice.
//   cnt_width(n)          : counter width able to hold 0..n, never less than 1
//   DEFAULT_STABLE_CYCLES : qualified samples needed to accept a new level
//   DEFAULT_SYNC_STAGES   : synchroniser depth per channel
//   edge_e                : kind of transition produced by a channel this cycle
package debounce_pkg;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 4;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer with symmetric hysteresis.
//   clk_i       : clock, all state on posedge
//   rst_ni      : asynchronous active-low reset
//   sample_en_i : sample qualifier for the counter/state (synchroniser always runs)
//   in_i        : raw asynchronous input
//   stable_o    : debounced level
//   rise_o      : one-cycle pulse, coincident with stable_o going 0->1
//   fall_o      : one-cycle pulse, coincident with stable_o going 1->0
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter bit          INIT_STATE    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sample_en_i,
    input  logic in_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CW   = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    edge_e                  edge_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{INIT_STATE}};
        end else begin
            sync_q[0] <= in_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Idle (unqualified) cycles hold the count, so a mismatch streak
    // survives gaps between sample strobes; only a matching sample clears it.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        edge_d   = EDGE_NONE;
        if (sample_en_i) begin
            if (s == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST) begin
                cnt_d    = '0;
                stable_d = s;
                edge_d   = s ? EDGE_RISE : EDGE_FALL;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = (edge_d == EDGE_RISE);
        fall_d = (edge_d == EDGE_FALL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            stable_q <= INIT_STATE;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: CHANNELS independent debounce_channel instances
// sharing one sample qualifier.
//   clk       : clock
//   reset     : asynchronous active-low reset
//   sample_en : sample qualifier (tie high to sample every cycle)
//   in        : raw asynchronous inputs, one bit per channel
//   stable    : debounced levels
//   rise      : one-cycle 0->1 pulses
//   fall      : one-cycle 1->0 pulses
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter bit          INIT_STATE    = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] stable,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .INIT_STATE    (INIT_STATE)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (reset),
            .sample_en_i (sample_en),
            .in_i        (in[c]),
            .stable_o    (stable[c]),
            .rise_o      (rise[c]),
            .fall_o      (fall[c])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: a default 4-channel instance plus a minimal
// 1-channel/1-cycle/1-stage instance. A reference model pushes the expected
// outputs of every clock edge into a queue; a monitor pops and compares on
// the following falling edge. Directed checks cover the latency points.
module tb_debounce_bank;

    localparam int NA = 4, SA = 4, YA = 2;
    localparam int NB = 1, SB = 1, YB = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [NA-1:0] in_a;
    logic [NA-1:0] stable_a, rise_a, fall_a;
    logic [NB-1:0] in_b;
    logic [NB-1:0] stable_b, rise_b, fall_b;
    logic          en_b = 1'b1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS(NA), .STABLE_CYCLES(SA), .SYNC_STAGES(YA), .INIT_STATE(1'b0)
    ) dut_a (
        .clk(clk), .reset(rst_n), .sample_en(en), .in(in_a),
        .stable(stable_a), .rise(rise_a), .fall(fall_a)
    );

    debounce_bank #(
        .CHANNELS(NB), .STABLE_CYCLES(SB), .SYNC_STAGES(YB), .INIT_STATE(1'b0)
    ) dut_b (
        .clk(clk), .reset(rst_n), .sample_en(en_b), .in(in_b),
        .stable(stable_b), .rise(rise_b), .fall(fall_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [NA-1:0] sa, ra, fa;
        logic [NB-1:0] sb, rb, fb;
    } exp_t;

    typedef struct packed {
        bit st;
        int run;
        bit r;
        bit f;
    } chres_t;

    // A new level is accepted once n consecutive qualified samples disagree
    // with the current debounced level.
    function automatic chres_t ch_step(int n, bit s, bit q, bit st, int run);
        chres_t o;
        o.st = st; o.run = run; o.r = 1'b0; o.f = 1'b0;
        if (q) begin
            if (s == st) o.run = 0;
            else if (run + 1 >= n) begin
                o.st = s; o.run = 0; o.r = s; o.f = !s;
            end else o.run = run + 1;
        end
        return o;
    endfunction

    bit          dqA[NA][$];
    bit          dqB[NB][$];
    bit [NA-1:0] stA;
    bit [NB-1:0] stB;
    int          runA[NA];
    int          runB[NB];
    exp_t        sbq[$];

    task automatic reset_model();
        stA = '0; stB = '0;
        for (int c = 0; c < NA; c++) begin
            runA[c] = 0; dqA[c].delete();
            repeat (YA) dqA[c].push_back(1'b0);
        end
        for (int c = 0; c < NB; c++) begin
            runB[c] = 0; dqB[c].delete();
            repeat (YB) dqB[c].push_back(1'b0);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        exp_t   e;
        chres_t o;
        bit     s;
        e = '0;
        if (!rst_n) begin
            reset_model();
            // Only a clock edge produces an output to be checked.
            if (clk) sbq.push_back(e);
        end else begin
            for (int c = 0; c < NA; c++) begin
                s = dqA[c].pop_back();
                dqA[c].push_front(in_a[c]);
                o = ch_step(SA, s, en, stA[c], runA[c]);
                stA[c] = o.st; runA[c] = o.run; e.ra[c] = o.r; e.fa[c] = o.f;
            end
            for (int c = 0; c < NB; c++) begin
                s = dqB[c].pop_back();
                dqB[c].push_front(in_b[c]);
                o = ch_step(SB, s, en_b, stB[c], runB[c]);
                stB[c] = o.st; runB[c] = o.run; e.rb[c] = o.r; e.fb[c] = o.f;
            end
            e.sa = stA; e.sb = stB;
            sbq.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check("sb_stable_a", 32'(stable_a), 32'(e.sa));
            check("sb_rise_a",   32'(rise_a),   32'(e.ra));
            check("sb_fall_a",   32'(fall_a),   32'(e.fa));
            check("sb_stable_b", 32'(stable_b), 32'(e.sb));
            check("sb_rise_b",   32'(rise_b),   32'(e.rb));
            check("sb_fall_b",   32'(fall_b),   32'(e.fb));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        in_b = '0;
        forever begin
            repeat (2) @(posedge clk);
            #2 in_b = ~in_b;
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; in_a = 4'hF;

        // Reset hold
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_stable", 32'(stable_a), 32'h0);
            check("reset_pulses", 32'({rise_a, fall_a}), 32'h0);
            #1;
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k < 6) check("release_early", 32'(stable_a), 32'h0);
            else begin
                check("release_stable6", 32'(stable_a), 32'hF);
                check("release_rise6",   32'(rise_a),   32'hF);
            end
            #1;
        end
        @(posedge clk); #1; check("release_rise7", 32'(rise_a), 32'h0); #1;

        // Falling edge on channel 2 only
        in_a = 4'hB;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k < 6) check("fall_early", 32'(stable_a), 32'hF);
            else begin
                check("fall_stable6", 32'(stable_a), 32'hB);
                check("fall_pulse6",  32'({rise_a, fall_a}), 32'h04);
            end
            #1;
        end
        @(posedge clk); #1; check("fall_pulse7", 32'(fall_a), 32'h0); #1;

        in_a = 4'h0;
        repeat (8) begin @(posedge clk); #2; end

        // Glitch of 3 cycles on channel 0 is rejected
        in_a = 4'h1;
        repeat (3) begin @(posedge clk); #2; end
        in_a = 4'h0;
        repeat (10) begin
            @(posedge clk); #1;
            check("glitch_stable0", 32'(stable_a[0]), 32'h0);
            check("glitch_rise0",   32'(rise_a[0]),   32'h0);
            #1;
        end
        in_a = 4'h1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) check("held_early0", 32'(stable_a[0]), 32'h0);
            if (k == 6) begin
                check("held_stable0", 32'(stable_a[0]), 32'h1);
                check("held_rise0",   32'(rise_a[0]),   32'h1);
            end
            #1;
        end

        // Qualified sampling: one strobe in four, channel 1 goes high
        for (int k = 0; k < 20; k++) begin
            en = (k % 4 == 0);
            if (k == 0) in_a = 4'h3;
            @(posedge clk); #1;
            if (!en) check("idle_pulses", 32'({rise_a, fall_a}), 32'h0);
            if (k == 15) check("qual_early1", 32'(stable_a[1]), 32'h0);
            if (k == 16) begin
                check("qual_stable1", 32'(stable_a[1]), 32'h1);
                check("qual_rise1",   32'(rise_a[1]),   32'h1);
            end
            #1;
        end
        en = 1'b1;
        repeat (4) begin @(posedge clk); #2; end

        // Asynchronous reset part-way through a count on channel 3
        in_a = 4'hB;
        repeat (4) @(posedge clk);
        #7 rst_n = 1'b0;
        #1;
        check("async_stable", 32'(stable_a), 32'h0);
        check("async_pulses", 32'({rise_a, fall_a}), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) check("rerelease_early", 32'(stable_a), 32'h0);
            if (k == 6) begin
                check("rerelease_stable6", 32'(stable_a), 32'hB);
                check("rerelease_rise6",   32'(rise_a),   32'hB);
            end
            #1;
        end

        repeat (6) begin @(posedge clk); #2; end
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
Multi-channel input debouncer with symmetric hysteresis, replacing the single-channel all-ones shift-register detector.
- Each channel synchronises an asynchronous raw input.
- A channel's debounced state changes only after the new level has been seen for STABLE_CYCLES consecutive qualified samples. This applies in both directions, rising and falling.
- Each channel emits one-cycle rise and fall pulses.
- Sits between board pins (keys, switches, sensors) and control FSMs.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- STABLE_CYCLES, 4, consecutive qualified samples required to accept a new level (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=1).
- INIT_STATE, 0, reset value of every debounced state bit (1 bit, applied to all channels).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- sample_en  input  1  sample qualifier: a tick strobe, or tie high to sample every cycle.
- in  input  CHANNELS  raw asynchronous inputs, one bit per channel.
- stable  output  CHANNELS  debounced level per channel.
- rise  output  CHANNELS  one-cycle pulse when stable goes 0->1.
- fall  output  CHANNELS  one-cycle pulse when stable goes 1->0.

Behaviour:
- Reset (reset==0, asynchronous, any time, including mid-count):
  - sync flops <= INIT_STATE.
  - counters <= 0.
  - stable <= INIT_STATE.
  - rise/fall <= 0.
- Reset release is synchronous to clk; the first counting edge is the first posedge with reset==1.
- Synchroniser: in[c] passes through SYNC_STAGES flops every clk, independent of sample_en. The synchronised bit is s[c].
- Counter per channel: width CW = $clog2(STABLE_CYCLES+1), saturating never needed. On each posedge with sample_en==1:
  - s[c]==stable[c]: cnt <= 0.
  - s[c]!=stable[c] and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s[c]!=stable[c] and cnt == STABLE_CYCLES-1: stable[c] <= s[c], cnt <= 0, and rise[c] or fall[c] <= 1 per direction.
- With sample_en==0:
  - cnt and stable hold.
  - rise/fall <= 0.
  - Mismatch streaks are not broken by idle cycles.
- Pulses:
  - rise/fall are registered and coincide with the cycle stable shows its new value.
  - Each is high exactly one cycle.
  - rise and fall are never both high for one channel.
- Latency (sample_en tied high): stable changes on the (SYNC_STAGES+STABLE_CYCLES)-th posedge after the first posedge that samples the new raw level. Defaults give 6 edges.
- Glitch rejection: any sample with s==stable before the count completes restarts the count from 0. Pulses shorter than STABLE_CYCLES qualified samples never reach stable.
- STABLE_CYCLES==1: the new level is accepted on the first differing qualified sample.
- Channels are fully independent; simultaneous transitions on several channels behave as if each were alone.

Decomposition:
- Package debounce_pkg:
  - Function cnt_width(n) returning $clog2(n+1), floored at 1.
  - Constants DEFAULT_STABLE_CYCLES=4 and DEFAULT_SYNC_STAGES=2.
- Sub-module debounce_channel (one bit): synchroniser, counter, state and pulse flops, same parameters minus CHANNELS.
- debounce_bank is a generate loop of CHANNELS instances, with sample_en fanned out to all of them.

Test Plan:
- Reset and hold: INIT_STATE=0, reset=0 for 3 cycles, in=4'hF. Required: stable=0, rise=0, fall=0 throughout. Then set reset=1 with in=4'hF and sample_en=1. Required: stable=4'hF and rise=4'hF on the 6th posedge after release, and rise=0 on the next cycle.
- Glitch reject: stable=0 settled, in[0]=1 for 3 cycles then 0, sample_en=1. Required: stable[0] stays 0 and rise[0] never asserts. Then in[0]=1 for 4 or more cycles. Required: stable[0]=1 exactly 6 edges after the first edge that samples in[0]=1.
- Falling edge: stable[2]=1, in[2]=0 held. Required: fall[2]=1 for one cycle, coincident with stable[2]=0, 6 edges later. Other channels unchanged.
- Qualified sampling: sample_en pulses 1 cycle in every 4, and in[1] goes 0->1 held. Required: stable[1] rises on the 4th qualified sample after s[1] changes. Stable is unchanged on unqualified edges, and rise/fall are 0 when sample_en=0.
- Async reset mid-operation: in[3]=1, then assert reset=0 between clock edges after 2 qualified samples. Required: stable, rise and fall clear immediately without waiting for clk. After release, the full 6-edge latency is required again; no partial count is retained.
- Parameter sweep: STABLE_CYCLES=1, SYNC_STAGES=1, CHANNELS=1, in toggling every 2 cycles. Required: stable follows in delayed 2 edges, with a rise/fall pulse on every transition.
